// File: rtl/rxuart_if.sv
// rtl/rxuart_if.sv - received-byte bus between rxuart and its consumer
interface rxuart_if;
    logic       o_wr;
    logic [7:0] o_data;
    logic       o_frame_err;
    logic       o_busy;

    modport master (output o_wr, output o_data, output o_frame_err, output o_busy);
    modport slave  (input  o_wr, input  o_data, input  o_frame_err, input  o_busy);
endinterface

// File: rtl/rxuart.sv
// rtl/rxuart.sv - 8N1 serial receiver, mid-bit sampling, one-cycle byte strobe
module rxuart #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd139
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_uart_rx,
    rxuart_if.master    rx_if
);

    localparam logic [23:0] HALF = CLOCKS_PER_BAUD >> 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START,
        S_BIT0, S_BIT1, S_BIT2, S_BIT3, S_BIT4, S_BIT5, S_BIT6, S_BIT7,
        S_STOP, S_BREAK
    } state_t;

    state_t      state, next_state;
    logic        rx_meta, rx_s;
    logic [23:0] counter;
    logic [7:0]  sreg;
    logic        load_half, load_baud, shift_en, wr_set, ferr_set;
    logic        sample;

    assign sample = (counter == 24'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_half  = 1'b0;
        load_baud  = 1'b0;
        shift_en   = 1'b0;
        wr_set     = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    next_state = S_START;
                    load_half  = 1'b1;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rx_s) begin
                        next_state = S_BIT0;
                        load_baud  = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_BIT0, S_BIT1, S_BIT2, S_BIT3, S_BIT4, S_BIT5, S_BIT6, S_BIT7: begin
                if (sample) begin
                    shift_en   = 1'b1;
                    load_baud  = 1'b1;
                    next_state = state_t'(state + 4'd1);
                end
            end
            S_STOP: begin
                if (sample) begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
                    if (rx_s) begin
                        wr_set     = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        next_state = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            counter <= 24'd0;
        end else if (load_half) begin
            counter <= HALF - 24'd1;
        end else if (load_baud) begin
            counter <= CLOCKS_PER_BAUD - 24'd1;
        end else if (state != S_IDLE && state != S_BREAK && counter != 24'd0) begin
            counter <= counter - 24'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg              <= 8'h00;
            rx_if.o_data      <= 8'h00;
            rx_if.o_wr        <= 1'b0;
            rx_if.o_frame_err <= 1'b0;
        end else begin
            if (shift_en) sreg <= {rx_s, sreg[7:1]};
            if (wr_set)   rx_if.o_data <= sreg;
            rx_if.o_wr        <= wr_set;
            rx_if.o_frame_err <= ferr_set;
        end
    end

    assign rx_if.o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_rxuart.sv
// tb/tb_rxuart.sv - directed vector bench for rxuart
module tb_rxuart;

    logic i_clk     = 1'b0;
    logic i_reset   = 1'b1;
    logic i_uart_rx = 1'b1;

    rxuart_if bus ();

    rxuart #(.CLOCKS_PER_BAUD(24'd139)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_uart_rx (i_uart_rx),
        .rx_if     (bus)
    );

    always #5 i_clk = ~i_clk;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_reset;
    end

    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0, ferr_cnt = 0, both_cnt = 0, wide_cnt = 0, glitch_cnt = 0;
    int         wr_cyc = -1;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;
    logic       prev_wr = 1'b0, prev_ferr = 1'b0;

    always @(negedge i_clk) begin
        if (bus.o_wr) begin
            wr_cnt++;
            last_data = bus.o_data;
            wr_cyc    = cyc;
        end
        if (bus.o_frame_err) ferr_cnt++;
        if (bus.o_wr && bus.o_frame_err) both_cnt++;
        if ((bus.o_wr && prev_wr) || (bus.o_frame_err && prev_ferr)) wide_cnt++;
        if (!rst_q && !bus.o_wr && bus.o_data !== prev_data) glitch_cnt++;
        prev_wr   = bus.o_wr;
        prev_ferr = bus.o_frame_err;
        prev_data = bus.o_data;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        i_uart_rx = v;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic stopv);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(b[i], n);
        send_bit(stopv, n);
    endtask

    typedef struct {
        logic [7:0] din;
        int         cpb;
        int         gap;
        int         exp_wr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[4];
    int   c0, w0, f0;

    initial begin
        vecs[0] = '{8'h00, 139, 0,   1, 8'h00};
        vecs[1] = '{8'hFF, 139, 300, 1, 8'hFF};
        vecs[2] = '{8'hC3, 135, 300, 1, 8'hC3};
        vecs[3] = '{8'hC3, 143, 300, 1, 8'hC3};

        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        check("reset_wr",   bus.o_wr,        0);
        check("reset_ferr", bus.o_frame_err, 0);
        check("reset_busy", bus.o_busy,      0);
        check("reset_data", bus.o_data,      0);
        send_bit(1'b1, 20);

        // 0x55: exact strobe cycle and busy onset
        c0 = cyc;
        fork
            send_frame(8'h55, 139, 1'b1);
            begin
                repeat (2) @(negedge i_clk);
                check("busy_at_edge", bus.o_busy, 0);
                @(negedge i_clk);
                check("busy_after_edge", bus.o_busy, 1);
            end
        join
        send_bit(1'b1, 200);
        check("x55_wr_cycle", wr_cyc - c0, 1323);
        check("x55_data", bus.o_data, 8'h55);
        check("x55_wr_count", wr_cnt, 1);
        check("x55_no_ferr", ferr_cnt, 0);

        for (int k = 0; k < 4; k++) begin
            w0 = wr_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[k].din, vecs[k].cpb, 1'b1);
            send_bit(1'b1, vecs[k].gap);
            check($sformatf("vec%0d_wr", k),   wr_cnt - w0,   vecs[k].exp_wr);
            check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, 0);
            check($sformatf("vec%0d_data", k), last_data,     vecs[k].exp_data);
        end

        // Bad stop bit followed by a held-low break
        w0 = wr_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 139, 1'b0);
        send_bit(1'b0, 3 * 139);
        check("break_busy_held", bus.o_busy, 1);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_no_wr", wr_cnt - w0, 0);
        check("break_data_kept", bus.o_data, 8'hC3);
        send_bit(1'b1, 300);
        check("break_idle", bus.o_busy, 0);
        check("break_ferr_once", ferr_cnt - f0, 1);
        send_frame(8'h3C, 139, 1'b1);
        send_bit(1'b1, 300);
        check("after_break_wr", wr_cnt - w0, 1);
        check("after_break_data", last_data, 8'h3C);

        // 20-clock low glitch is rejected at the start sample
        w0 = wr_cnt;
        f0 = ferr_cnt;
        fork
            begin
                send_bit(1'b0, 20);
                send_bit(1'b1, 300);
            end
            begin
                repeat (71) @(negedge i_clk);
                check("glitch_busy_start", bus.o_busy, 1);
                @(negedge i_clk);
                check("glitch_busy_drop", bus.o_busy, 0);
            end
        join
        check("glitch_no_wr", wr_cnt - w0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'hA5, 139, 1'b1);
        send_bit(1'b1, 300);
        check("after_glitch_data", last_data, 8'hA5);
        check("after_glitch_wr", wr_cnt - w0, 1);

        // Reset in the middle of bit 4 of 0x81
        w0 = wr_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0, 139);
        send_bit(1'b1, 139);
        send_bit(1'b0, 139);
        send_bit(1'b0, 139);
        send_bit(1'b0, 139);
        send_bit(1'b0, 40);
        check("mid_frame_busy", bus.o_busy, 1);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset   = 1'b0;
        i_uart_rx = 1'b1;
        check("rst_mid_busy", bus.o_busy,      0);
        check("rst_mid_wr",   bus.o_wr,        0);
        check("rst_mid_ferr", bus.o_frame_err, 0);
        check("rst_mid_data", bus.o_data,      0);
        send_bit(1'b1, 1500);
        check("rst_mid_no_wr",   wr_cnt - w0,   0);
        check("rst_mid_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h7E, 139, 1'b1);
        send_bit(1'b1, 300);
        check("after_rst_data", bus.o_data, 8'h7E);
        check("after_rst_wr", wr_cnt - w0, 1);

        check("wr_ferr_overlap", both_cnt, 0);
        check("strobe_width", wide_cnt, 0);
        check("data_stable", glitch_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
